// File: rtl/chip_clock_sequencer.sv
// Chip clock/reset generator for the debug harness.
// Steps, free-runs or reset-clocks the target chip from clk100.
module chip_clock_sequencer #(
    parameter int HALF_PERIOD = 4,
    parameter int CNT_W       = 16,
    parameter int IO_W        = 12
) (
    input  logic             clk100,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [IO_W-1:0]  chip_outputs,
    output logic             chip_clock,
    output logic             chip_reset,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    output logic [IO_W-1:0]  sample_data
);

    localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_RUN,
        S_RESET
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] remaining;
    logic             halt_pend;

    logic accept;
    logic running;
    logic ph_end;
    logic halt_cmd;
    logic stop_low;
    logic rise;
    logic fall;
    logic last;
    logic cnt_zero;

    assign cmd_ready = (state == S_IDLE) || (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign running   = (state != S_IDLE);
    assign ph_end    = (phase == PH_LAST);
    assign halt_cmd  = accept && (cmd_op == OP_HALT);
    // A HALT during the low phase wins over a coincident rising edge.
    assign stop_low  = (state == S_RUN) && halt_cmd && !chip_clock;
    assign rise      = running && ph_end && !chip_clock && !stop_low;
    assign fall      = running && ph_end && chip_clock;
    assign last      = (remaining == CNT_W'(1));
    assign cnt_zero  = (cmd_count == '0);

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            phase        <= '0;
            remaining    <= '0;
            halt_pend    <= 1'b0;
            chip_clock   <= 1'b0;
            chip_reset   <= 1'b1;
            done         <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else begin
            done         <= 1'b0;
            sample_valid <= 1'b0;

            if (running) begin
                phase <= ph_end ? '0 : phase + 1'b1;
            end

            if (rise) begin
                chip_clock   <= 1'b1;
                sample_data  <= chip_outputs;
                sample_valid <= 1'b1;
            end

            if (fall) begin
                chip_clock <= 1'b0;
                if (state != S_RUN) begin
                    remaining <= remaining - 1'b1;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (cmd_op)
                            OP_HALT: done <= 1'b1;
                            OP_STEP: begin
                                if (cnt_zero) begin
                                    done <= 1'b1;
                                end else begin
                                    state     <= S_STEP;
                                    remaining <= cmd_count;
                                end
                            end
                            OP_RUN: begin
                                state     <= S_RUN;
                                halt_pend <= 1'b0;
                            end
                            OP_RESET: begin
                                state      <= S_RESET;
                                chip_reset <= 1'b1;
                                remaining  <= cnt_zero ? CNT_W'(1)
                                                       : cmd_count;
                            end
                        endcase
                    end
                end
                S_STEP: begin
                    if (fall && last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_RESET: begin
                    if (fall && last) begin
                        state      <= S_IDLE;
                        done       <= 1'b1;
                        chip_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop_low) begin
                        state     <= S_IDLE;
                        phase     <= '0;
                        halt_pend <= 1'b0;
                        done      <= 1'b1;
                    end else if (fall && (halt_pend || halt_cmd)) begin
                        state     <= S_IDLE;
                        halt_pend <= 1'b0;
                        done      <= 1'b1;
                    end else if (halt_cmd) begin
                        halt_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
